// File: rtl/reg_exec_stage.sv
// Execute/write-back stage: reads two operands from a 32-entry register file,
// forwards any pending write-back, runs the ALU, and registers the result.
// The registered result is written back to the register file one edge later.
// A side-band preload port writes register contents directly.
module reg_exec_stage #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             in_valid,
  input  logic [1:0]       op,
  input  logic [4:0]       waddr,
  input  logic [4:0]       raddr1,
  input  logic [4:0]       raddr2,
  input  logic             init_we,
  input  logic [4:0]       init_addr,
  input  logic [WIDTH-1:0] init_data,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       result_addr,
  output logic             result_valid,
  output logic             zero,
  output logic             ovf
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } alu_op_e;

  logic [WIDTH-1:0] regs [DEPTH];

  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  alu_op_e          alu_op;

  assign alu_op = alu_op_e'(op);

  // Operand select: r0 reads zero, a pending write-back to the same register
  // is forwarded, otherwise the register file supplies the value.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    opa = '0;
    opb = '0;
    if (raddr1 != 5'd0) begin
      if (result_valid && (result_addr == raddr1)) opa = result;
      else                                         opa = regs[raddr1];
    end
    if (raddr2 != 5'd0) begin
      if (result_valid && (result_addr == raddr2)) opb = result;
      else                                         opb = regs[raddr2];
    end
  end

  // ALU: wrap-around add/sub with signed-overflow detection, bitwise AND/OR.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    unique case (alu_op)
      OP_ADD: begin
        alu_res = opa + opb;
        alu_ovf = (opa[WIDTH-1] == opb[WIDTH-1]) && (alu_res[WIDTH-1] != opa[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = opa - opb;
        alu_ovf = (opa[WIDTH-1] != opb[WIDTH-1]) && (alu_res[WIDTH-1] != opa[WIDTH-1]);
      end
      OP_AND:  alu_res = opa & opb;
      OP_OR:   alu_res = opa | opb;
      default: alu_res = '0;
    endcase
  end

  // Write-back stage register: loaded on issue; on a bubble only the valid
  // flag drops so the last result stays visible.
  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      result       <= '0;
      result_addr  <= '0;
      result_valid <= 1'b0;
      zero         <= 1'b0;
      ovf          <= 1'b0;
    end else if (in_valid) begin
      result       <= alu_res;
      result_addr  <= waddr;
      result_valid <= (waddr != 5'd0);
      zero         <= (alu_res == '0);
      ovf          <= alu_ovf;
    end else begin
      result_valid <= 1'b0;
    end
  end

  // Register file: write-back first, preload second so a preload to the same
  // address on the same edge takes precedence. Address 0 is never written.
  // NOTE: the register file is cleared by reset because its contents are
  // architecturally visible zeros after reset, so it is built from flops.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (result_valid && (result_addr != 5'd0)) regs[result_addr] <= result;
      if (init_we && (init_addr != 5'd0))        regs[init_addr]   <= init_data;
    end
  end

endmodule

// File: tb/tb_reg_exec_stage.sv
// Directed bench for reg_exec_stage. Inputs change on the falling edge and
// outputs are sampled on the falling edge, half a cycle after the rising edge.
module tb_reg_exec_stage;

  localparam int WIDTH = 8;
  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, AND_ = 2'b10, OR_ = 2'b11;

  logic             clk = 1'b0;
  logic             rstN;
  logic             in_valid;
  logic [1:0]       op;
  logic [4:0]       waddr, raddr1, raddr2;
  logic             init_we;
  logic [4:0]       init_addr;
  logic [WIDTH-1:0] init_data;
  logic [WIDTH-1:0] result;
  logic [4:0]       result_addr;
  logic             result_valid;
  logic             zero;
  logic             ovf;

  int n_checks = 0;
  int n_fail   = 0;

  reg_exec_stage #(.WIDTH(WIDTH), .DEPTH(32)) dut (
    .clk          (clk),
    .rstN         (rstN),
    .in_valid     (in_valid),
    .op           (op),
    .waddr        (waddr),
    .raddr1       (raddr1),
    .raddr2       (raddr2),
    .init_we      (init_we),
    .init_addr    (init_addr),
    .init_data    (init_data),
    .result       (result),
    .result_addr  (result_addr),
    .result_valid (result_valid),
    .zero         (zero),
    .ovf          (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] res, input logic [4:0] addr,
                           input logic vld, input logic z, input logic o);
    check({tag, ".result"},       32'(result),       32'(res));
    check({tag, ".result_addr"},  32'(result_addr),  32'(addr));
    check({tag, ".result_valid"}, 32'(result_valid), 32'(vld));
    check({tag, ".zero"},         32'(zero),         32'(z));
    check({tag, ".ovf"},          32'(ovf),          32'(o));
  endtask

  // Apply one cycle of inputs, then wait for the falling edge after the
  // rising edge that consumes them.
  task automatic cycle(input logic iv, input logic [1:0] o, input logic [4:0] w,
                       input logic [4:0] a, input logic [4:0] b,
                       input logic iwe, input logic [4:0] ia, input logic [7:0] id);
    in_valid  = iv;
    op        = o;
    waddr     = w;
    raddr1    = a;
    raddr2    = b;
    init_we   = iwe;
    init_addr = ia;
    init_data = id;
    @(negedge clk);
  endtask

  task automatic issue(input logic [1:0] o, input logic [4:0] w, input logic [4:0] a, input logic [4:0] b);
    cycle(1'b1, o, w, a, b, 1'b0, 5'd0, 8'h00);
  endtask

  task automatic preload(input logic [4:0] a, input logic [7:0] d);
    cycle(1'b0, ADD, 5'd0, 5'd0, 5'd0, 1'b1, a, d);
  endtask

  task automatic bubble();
    cycle(1'b0, ADD, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 8'h00);
  endtask

  // Observe a register by OR-ing it with itself into r0 (no write-back).
  task automatic read_reg(input string tag, input logic [4:0] a, input logic [7:0] exp);
    issue(OR_, 5'd0, a, a);
    check(tag, 32'(result), 32'(exp));
  endtask

  initial begin
    rstN = 1'b0;
    in_valid = 1'b0; op = ADD; waddr = '0; raddr1 = '0; raddr2 = '0;
    init_we = 1'b0; init_addr = '0; init_data = '0;
    @(negedge clk);
    @(negedge clk);
    check_out("reset", 8'h00, 5'd0, 1'b0, 1'b0, 1'b0);
    rstN = 1'b1;

    // Basic ADD and write-back
    preload(5'd1, 8'd5);
    preload(5'd2, 8'd3);
    issue(ADD, 5'd3, 5'd1, 5'd2);
    check_out("add_basic", 8'd8, 5'd3, 1'b1, 1'b0, 1'b0);
    bubble();
    check_out("bubble_hold", 8'd8, 5'd3, 1'b0, 1'b0, 1'b0);
    read_reg("wb_r3", 5'd3, 8'd8);

    // Back-to-back dependency: r3 holds a stale 0x20 so only forwarding gives 3
    preload(5'd3, 8'h20);
    issue(ADD, 5'd3, 5'd1, 5'd2);
    issue(SUB, 5'd4, 5'd3, 5'd1);
    check_out("fwd_sub", 8'd3, 5'd4, 1'b1, 1'b0, 1'b0);
    preload(5'd3, 8'h20);
    issue(ADD, 5'd3, 5'd1, 5'd2);
    bubble();
    issue(SUB, 5'd4, 5'd3, 5'd1);
    check_out("rf_sub", 8'd3, 5'd4, 1'b1, 1'b0, 1'b0);

    // Overflow, wrap and zero flag
    preload(5'd1, 8'h7F);
    preload(5'd2, 8'h01);
    issue(ADD, 5'd5, 5'd1, 5'd2);
    check_out("add_ovf", 8'h80, 5'd5, 1'b1, 1'b0, 1'b1);
    preload(5'd6, 8'h80);
    issue(SUB, 5'd7, 5'd6, 5'd2);
    check_out("sub_ovf", 8'h7F, 5'd7, 1'b1, 1'b0, 1'b1);
    issue(SUB, 5'd8, 5'd1, 5'd1);
    check_out("sub_zero", 8'h00, 5'd8, 1'b1, 1'b1, 1'b0);
    issue(AND_, 5'd14, 5'd1, 5'd2);
    check_out("and", 8'h01, 5'd14, 1'b1, 1'b0, 1'b0);
    issue(OR_, 5'd15, 5'd6, 5'd1);
    check_out("or_no_ovf", 8'hFF, 5'd15, 1'b1, 1'b0, 1'b0);

    // Preload and issue in the same cycle: operand sees the pre-edge value
    cycle(1'b1, OR_, 5'd0, 5'd13, 5'd13, 1'b1, 5'd13, 8'h40);
    check("same_cycle_pre", 32'(result), 32'h00);
    read_reg("same_cycle_post", 5'd13, 8'h40);

    // Register 0
    preload(5'd0, 8'hAA);
    issue(OR_, 5'd9, 5'd0, 5'd0);
    check_out("r0_read", 8'h00, 5'd9, 1'b1, 1'b1, 1'b0);
    issue(ADD, 5'd0, 5'd1, 5'd2);
    check_out("r0_write", 8'h80, 5'd0, 1'b0, 1'b0, 1'b1);
    read_reg("r0_after", 5'd0, 8'h00);

    // Preload beats write-back on the same edge; the read that cycle forwards
    issue(AND_, 5'd10, 5'd1, 5'd2);
    check_out("conf_and", 8'h01, 5'd10, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, OR_, 5'd0, 5'd10, 5'd10, 1'b1, 5'd10, 8'h55);
    check("conf_fwd", 32'(result), 32'h01);
    read_reg("conf_rf", 5'd10, 8'h55);

    // Reset mid-operation drops the pending write-back
    issue(ADD, 5'd11, 5'd1, 5'd2);
    check_out("pre_reset", 8'h80, 5'd11, 1'b1, 1'b0, 1'b1);
    in_valid = 1'b0;
    rstN = 1'b0;
    #2;
    check_out("async_reset", 8'h00, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_out("reset_held", 8'h00, 5'd0, 1'b0, 1'b0, 1'b0);
    rstN = 1'b1;
    read_reg("r11_dropped", 5'd11, 8'h00);
    read_reg("r1_cleared", 5'd1, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/reg_exec_stage.md
Name: reg_exec_stage

Overview:
- Execute/write-back stage directly downstream of instruction fetch.
- Consumes the fetch stage's decoded fields (op, waddr, raddr1, raddr2), reads two operands from an internal 32-entry register file, and performs the ALU operation.
- Registers the result and writes it back one cycle later.
- Forwards the pending write-back so that back-to-back dependent instructions see correct values.
- Provides a side-band preload port so the bench or system can initialise register contents.

Parameters:
- WIDTH, 8, data width of each register and of the ALU.
- DEPTH, 32, number of registers. Fixed to 32 to match the 5-bit address fields.

Ports:
- clk  input  1  clock; all state updates on its rising edge
- rstN  input  1  asynchronous active-low reset
- in_valid  input  1  fetch fields are valid this cycle
- op  input  2  ALU op: 00 ADD, 01 SUB, 10 AND, 11 OR
- waddr  input  5  destination register
- raddr1  input  5  source register A
- raddr2  input  5  source register B
- init_we  input  1  preload write enable
- init_addr  input  5  preload address
- init_data  input  WIDTH  preload data
- result  output  WIDTH  registered ALU result (write-back stage)
- result_addr  output  5  destination of the result
- result_valid  output  1  result/result_addr hold a pending write-back
- zero  output  1  registered: result == 0
- ovf  output  1  registered: signed overflow of ADD/SUB; 0 for AND/OR

Behaviour:
- Reset (rstN low, asynchronous):
  - All registers, result, result_addr, result_valid, zero and ovf go to 0 immediately.
  - They are held at 0 while rstN is low.
- Register 0 is hardwired zero:
  - Reads return 0.
  - Writes to address 0 from either source are discarded.
  - Address 0 never forwards.
- Operand read is combinational in the issue cycle. For each source s in {raddr1, raddr2}:
  - if s == 0: operand = 0;
  - else if result_valid && result_addr == s: operand = result (forwarding);
  - else: operand = regfile[s].
- Execute:
  - ADD is A+B modulo 2^WIDTH; SUB is A-B modulo 2^WIDTH.
  - ovf is set when both operands have the same sign (ADD), or different signs (SUB), and the result sign differs from A's sign.
  - AND and OR are bitwise.
- Issue (rising edge with in_valid=1):
  - result, result_addr and zero are loaded from the ALU.
  - ovf is loaded; it is 0 for AND/OR.
  - result_valid is set to (waddr != 0).
- Latency:
  - Issue at edge N; result visible after edge N.
  - regfile[waddr] is updated at edge N+1.
  - An instruction issued in cycle N+1 that reads waddr gets the value via forwarding.
  - From cycle N+2 onward the value comes from the regfile.
- Write-back:
  - At every rising edge with result_valid=1, regfile[result_addr] <= result.
  - If the same edge has in_valid=0, result_valid clears. result, result_addr, zero and ovf hold their previous values.
- Bubble: in_valid=0 means no ALU update.
- Preload: at a rising edge with init_we=1 and init_addr != 0, regfile[init_addr] <= init_data.
- Simultaneous events:
  - Preload and write-back to the same address at the same edge: preload wins.
  - In the cycle before that edge, reads of that address still forward the pending result.
  - Preload does not affect result_valid or the forwarding logic.
  - Preload and issue in the same cycle are legal. Operands use the pre-edge register state.
- Reset mid-operation: any pending write-back is dropped and is not written after reset is released.
- No stalls and no backpressure: one instruction per cycle is accepted whenever in_valid=1.

Test Plan:
- Reset, then preload r1=5 and r2=3, then issue ADD r3,r1,r2 -> result=8, result_addr=3, result_valid=1, zero=0, ovf=0; regfile[3]=8 one edge later.
- Back-to-back dependency: ADD r3,r1,r2 then SUB r4,r3,r1 in consecutive cycles -> second result=3 via forwarding. Repeat with one bubble between them -> still 3, now read from the regfile.
- Overflow/wrap: preload r1=0x7F, r2=0x01; ADD r5,r1,r2 -> result=0x80, ovf=1. Preload r6=0x80; SUB r7,r6,r2 -> result=0x7F, ovf=1. SUB r8,r1,r1 -> result=0, zero=1.
- Register 0: preload r0=0xAA, then OR r9,r0,r0 -> result=0. ADD r0,r1,r2 -> result_valid=0, and a subsequent read of r0 returns 0.
- Conflict: issue AND r10,r1,r2, then on the write-back edge preload r10=0x55 -> regfile[10]=0x55. A read of r10 in the following cycle returns 0x55.
- Reset mid-operation: issue ADD r11,r1,r2 and pulse rstN low before the write-back edge -> all outputs read 0. After release, a read of r11 returns 0.
